// File: rtl/wb_scrub_master.sv
// rtl/wb_scrub_master.sv - Wishbone initiator that sweeps the ECC register file with read/write-back pairs.
// Optional periodic auto-start is enabled by defining SCRUB_AUTO_EN.
module wb_scrub_master #(
  parameter int                      WORD_SIZE    = 32,
  parameter int                      REGISTERS    = 32,
  parameter int                      REGDIRSIZE   = 5,
  parameter int                      WHISBONE_ADR = 32,
  parameter logic [WHISBONE_ADR-1:0] BASE_ADR     = 32'h3000_0000,
  parameter int                      ADR_STRIDE   = 4,
  parameter int                      TIMEOUT      = 16,
  parameter int                      COUNTERSIZE  = 32
`ifdef SCRUB_AUTO_EN
  ,
  parameter int                      SCRUB_PERIOD = 1024
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [COUNTERSIZE-1:0]  sweep_count_o,
  output logic [COUNTERSIZE-1:0]  err_count_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [3:0]              wbm_sel_o,
  output logic [WHISBONE_ADR-1:0] wbm_adr_o,
  output logic [WORD_SIZE-1:0]    wbm_dat_o,
  input  logic [WORD_SIZE-1:0]    wbm_dat_i,
  input  logic                    wbm_ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_WRITE, S_NEXT, S_DONE} state_t;

  state_t                  state_q;
  logic [REGDIRSIZE-1:0]   idx_q;
  logic [TW-1:0]           to_q;
  logic                    busy_q, done_q, timeout_q;
  logic                    cyc_q, we_q;
  logic [3:0]              sel_q;
  logic [WHISBONE_ADR-1:0] adr_q;
  logic [WORD_SIZE-1:0]    dat_q;
  logic [COUNTERSIZE-1:0]  sweep_q, err_q;
  logic                    start_req;
  logic                    to_expire;
  logic                    last_idx;

`ifdef SCRUB_AUTO_EN
  localparam int PW = $clog2(SCRUB_PERIOD + 1);
  logic [PW-1:0] per_q;
  logic          per_hit;

  assign per_hit   = (state_q == S_IDLE) && (per_q == PW'(SCRUB_PERIOD - 1));
  assign start_req = start_i | per_hit;

  // Period counter only runs while idle; any sweep start restarts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_q <= '0;
    end else if (state_q != S_IDLE || start_req) begin
      per_q <= '0;
    end else begin
      per_q <= per_q + PW'(1);
    end
  end
`else
  assign start_req = start_i;
`endif

  assign to_expire = (to_q == TW'(TIMEOUT - 1));
  assign last_idx  = (idx_q == REGDIRSIZE'(REGISTERS - 1));

  function automatic logic [WHISBONE_ADR-1:0] adr_of(input logic [REGDIRSIZE-1:0] i);
    return BASE_ADR + WHISBONE_ADR'(i) * WHISBONE_ADR'(ADR_STRIDE);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      to_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= '0;
      dat_q     <= '0;
      sweep_q   <= '0;
      err_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            state_q <= S_READ;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'hF;
            adr_q   <= adr_of('0);
            to_q    <= '0;
          end
        end
        S_READ: begin
          if (wbm_ack_i) begin
            dat_q   <= wbm_dat_i;
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
            state_q <= S_GAP;
          end else if (to_expire) begin
            // Abandoned read: no write-back for this entry.
            cyc_q     <= 1'b0;
            sel_q     <= 4'h0;
            timeout_q <= 1'b1;
            if (err_q != '1) err_q <= err_q + COUNTERSIZE'(1);
            state_q   <= S_NEXT;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        S_GAP: begin
          state_q <= S_WRITE;
          cyc_q   <= 1'b1;
          we_q    <= 1'b1;
          sel_q   <= 4'hF;
          to_q    <= '0;
        end
        S_WRITE: begin
          if (wbm_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            state_q <= S_NEXT;
          end else if (to_expire) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            timeout_q <= 1'b1;
            if (err_q != '1) err_q <= err_q + COUNTERSIZE'(1);
            state_q   <= S_NEXT;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        S_NEXT: begin
          if (last_idx) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            sweep_q <= sweep_q + COUNTERSIZE'(1);
          end else begin
            idx_q   <= idx_q + REGDIRSIZE'(1);
            adr_q   <= adr_of(idx_q + REGDIRSIZE'(1));
            cyc_q   <= 1'b1;
            sel_q   <= 4'hF;
            to_q    <= '0;
            state_q <= S_READ;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign sweep_count_o = sweep_q;
  assign err_count_o   = err_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;

endmodule
